// File: rtl/cpu_sequencer_pkg.sv
// Shared rvcpu types: sequencer states, PC step and the ALU opcode width.
package rvcpu;

  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned PC_STEP = 4;

  typedef logic [ALUOP_W-1:0] aluop_t;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter register with reset load, +PC_STEP path and branch target mux.
module pc_unit
  import rvcpu::*;
#(
  parameter int unsigned     Width   = 32,
  parameter logic [Width-1:0] ResetPc = '0
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             advance_i,
  input  logic             branch_taken_i,
  input  logic [Width-1:0] imm_i,
  output logic [Width-1:0] pc_o
);

  logic [Width-1:0] pc_q;
  logic [Width-1:0] pc_d;

  // Additions wrap modulo 2^Width by construction.
  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      pc_d = pc_q + (branch_taken_i ? imm_i : Width'(PC_STEP));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the rvcpu core.
// Optional conditional branches are enabled by defining SEQ_BRANCH_EN.
module cpu_sequencer
  import rvcpu::*;
#(
  parameter int unsigned      Width   = 32,
  parameter logic [Width-1:0] ResetPc = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_valid,
  input  logic               imem_ready,
  input  logic [Width-1:0]   instr,
  output logic [Width-1:0]   pc,
  output logic [Width-1:0]   ir,
  input  logic               dec_rs1_valid,
  input  logic               dec_rs2_valid,
  input  logic               dec_rw_valid,
  input  logic [ALUOP_W-1:0] dec_aluop,
  input  logic               dec_illegal,
  input  logic               dec_branch,
  input  logic               dec_branch_ne,
  input  logic [Width-1:0]   dec_imm,
  input  logic               alu_is_zero,
  output logic               rf_rs1_valid,
  output logic               rf_rs2_valid,
  output logic               rf_rw_valid,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               retire,
  output logic               halted
);

  seq_state_t       state_q, state_d;
  logic [Width-1:0] ir_q, ir_d;
  logic             imem_valid_q, imem_valid_d;
  logic             rd_en_q, rd_en_d;
  logic             rw_q, rw_d;
  logic             retire_q, retire_d;
  logic             halted_q, halted_d;
  aluop_t           alu_op_q, alu_op_d;
  logic             branch_taken;
  logic [Width-1:0] branch_imm;

`ifdef SEQ_BRANCH_EN
  assign branch_taken = dec_branch & (alu_is_zero ^ dec_branch_ne);
  assign branch_imm   = dec_imm;
`else
  logic unused_branch;
  assign unused_branch = ^{dec_branch, dec_branch_ne, dec_imm, alu_is_zero};
  assign branch_taken  = 1'b0;
  assign branch_imm    = '0;
`endif

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    imem_valid_d = 1'b0;
    rd_en_d      = 1'b0;
    rw_d         = 1'b0;
    retire_d     = 1'b0;
    halted_d     = 1'b0;
    alu_op_d     = '0;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = dec_illegal ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase

    imem_valid_d = (state_d == S_FETCH);
    halted_d     = (state_d == S_HALT);
    rd_en_d      = (state_d == S_DECODE) || (state_d == S_EXECUTE);
    retire_d     = (state_d == S_WRITEBACK);
    rw_d         = (state_d == S_WRITEBACK) && dec_rw_valid;
    if (state_d == S_EXECUTE) begin
      alu_op_d = dec_aluop;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      ir_q         <= '0;
      imem_valid_q <= 1'b1;
      rd_en_q      <= 1'b0;
      rw_q         <= 1'b0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      alu_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      imem_valid_q <= imem_valid_d;
      rd_en_q      <= rd_en_d;
      rw_q         <= rw_d;
      retire_q     <= retire_d;
      halted_q     <= halted_d;
      alu_op_q     <= alu_op_d;
    end
  end

  pc_unit #(
    .Width   (Width),
    .ResetPc (ResetPc)
  ) u_pc_unit (
    .clk            (clk),
    .reset_ni       (reset),
    .advance_i      (state_q == S_WRITEBACK),
    .branch_taken_i (branch_taken),
    .imm_i          (branch_imm),
    .pc_o           (pc)
  );

  // Read flags follow ir, which loads on the DECODE entry edge, so they are gated here.
  assign rf_rs1_valid = rd_en_q & ~dec_illegal & dec_rs1_valid;
  assign rf_rs2_valid = rd_en_q & ~dec_illegal & dec_rs2_valid;
  assign rf_rw_valid  = rw_q;
  assign retire       = retire_q;
  assign halted       = halted_q;
  assign imem_valid   = imem_valid_q;
  assign alu_op       = alu_op_q;
  assign ir           = ir_q;

endmodule
